// File: rtl/led_seq_gen.sv
// LED fill-animation sequencer: CLEAR, FILL_L, FILL_R, FILL_IN, FILL_OUT.
// Define LEDSEQ_ACTIVE_LOW_EN to drive led inverted for active-low boards.
module led_seq_gen #(
  parameter int WIDTH = 12,
  parameter int DIV   = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             mode,
  input  logic [1:0]       phase_sel,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       phase,
  output logic             step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int H  = WIDTH / 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  localparam logic [2:0] CLEAR    = 3'd0;
  localparam logic [2:0] FILL_L   = 3'd1;
  localparam logic [2:0] FILL_R   = 3'd2;
  localparam logic [2:0] FILL_IN  = 3'd3;
  localparam logic [2:0] FILL_OUT = 3'd4;

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] nxt_pat;
  logic [2:0]       nxt_phase;
  logic [2:0]       sel_phase;

  function automatic logic [WIDTH-1:0] seed_of(
    input logic [2:0] p
  );
    logic [WIDTH-1:0] s;
    s = '0;
    case (p)
      FILL_L: s[0] = 1'b1;
      FILL_R: s[WIDTH-1] = 1'b1;
      FILL_IN: begin
        s[WIDTH-1] = 1'b1;
        s[0]       = 1'b1;
      end
      FILL_OUT: begin
        s[H]   = 1'b1;
        s[H-1] = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] shift_of(
    input logic [2:0]       p,
    input logic [WIDTH-1:0] v
  );
    logic [H-1:0]     u;
    logic [H-1:0]     l;
    logic [WIDTH-1:0] r;
    u = v[WIDTH-1:H];
    l = v[H-1:0];
    case (p)
      FILL_L:   r = {v[WIDTH-2:0], 1'b1};
      FILL_R:   r = {1'b1, v[WIDTH-1:1]};
      FILL_IN:  r = {1'b1, u[H-1:1], l[H-2:0], 1'b1};
      FILL_OUT: r = {u[H-2:0], 1'b1, 1'b1, l[H-1:1]};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign tick      = (cnt == CNT_MAX) && !pause;
  assign sel_phase = {1'b0, phase_sel} + 3'd1;

  always_comb begin
    nxt_phase = phase;
    nxt_pat   = pat;
    case (phase)
      CLEAR: begin
        nxt_phase = mode ? sel_phase : FILL_L;
        nxt_pat   = seed_of(nxt_phase);
      end
      FILL_L, FILL_R, FILL_IN, FILL_OUT: begin
        if (&pat) begin
          if (mode || phase == FILL_OUT)
            nxt_phase = CLEAR;
          else
            nxt_phase = phase + 3'd1;
          nxt_pat = seed_of(nxt_phase);
        end else begin
          nxt_pat = shift_of(phase, pat);
        end
      end
      default: begin
        nxt_phase = CLEAR;
        nxt_pat   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= CLEAR;
      pat   <= '0;
      step  <= 1'b0;
    end else begin
      step <= tick;
      if (tick)
        cnt <= '0;
      else if (!pause)
        cnt <= cnt + CW'(1);
      // an out-of-range encoding recovers without waiting for a step
      if (phase > FILL_OUT) begin
        phase <= CLEAR;
        pat   <= '0;
      end else if (tick) begin
        phase <= nxt_phase;
        pat   <= nxt_pat;
      end
    end
  end

`ifdef LEDSEQ_ACTIVE_LOW_EN
  assign led = ~pat;
`else
  assign led = pat;
`endif

endmodule
